vread: RTL and testbench

- Upstream counterpart of the write-back stage: a Versat read unit.
- A DMA engine fetches `size` words from external memory over the databus into a local 2-port RAM.
- A programmable address generator (B side) then streams RAM contents onto `out0` for the datapath.
- Fetch (A side) and stream (B side) start together on `run`. `done` rises when both finish.

---
 rtl/versat_io_pkg.sv | 19 +
 rtl/vread_if.sv | 15 +
 rtl/iob_2p_ram.sv | 25 ++
 rtl/vread_dma.sv | 67 ++++++
 rtl/xaddrgen2.sv | 101 ++++++++++
 rtl/vread.sv | 86 ++++++++
 tb/tb_vread.sv | 164 ++++++++++++++++
 7 files changed

// File: rtl/versat_io_pkg.sv
// Shared defaults, constants and state encodings for the Versat I/O units.
package versat_io_pkg;

    localparam int unsigned DATA_W_DEF     = 32;
    localparam int unsigned IO_ADDR_W_DEF  = 32;
    localparam int unsigned IO_SIZE_W_DEF  = 11;
    localparam int unsigned MEM_ADDR_W_DEF = 10;
    localparam int unsigned PERIOD_W_DEF   = 10;
    localparam int unsigned BYTES_PER_WORD = DATA_W_DEF / 8;

    typedef enum logic { IDLE = 1'b0, FETCH = 1'b1 } fetch_state_t;

    typedef enum logic [1:0] { AG_IDLE = 2'd0, AG_DELAY = 2'd1, AG_RUN = 2'd2 } agen_state_t;

    function automatic int unsigned bytes_per_word(input int unsigned data_w);
        return data_w / 8;
    endfunction

endpackage

// File: rtl/vread_if.sv
// External read databus: request/address out, ready/read data back.
interface vread_if import versat_io_pkg::*; #(
    parameter int unsigned DATA_W    = DATA_W_DEF,
    parameter int unsigned IO_ADDR_W = IO_ADDR_W_DEF
);
    logic                 valid;
    logic                 ready;
    logic [IO_ADDR_W-1:0] addr;
    logic [DATA_W-1:0]    rdata;
    logic [DATA_W-1:0]    wdata;
    logic [DATA_W/8-1:0]  wstrb;

    modport master (output valid, addr, wdata, wstrb, input ready, rdata);
    modport slave  (input valid, addr, wdata, wstrb, output ready, rdata);
endinterface

// File: rtl/iob_2p_ram.sv
// Simple dual-port RAM: one write port, one registered read port (old data on collision).
module iob_2p_ram #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 10
) (
    input  logic              clk,
    input  logic              w_en,
    input  logic [ADDR_W-1:0] w_addr,
    input  logic [DATA_W-1:0] w_data,
    input  logic              r_en,
    input  logic [ADDR_W-1:0] r_addr,
    output logic [DATA_W-1:0] r_data
);
    logic [DATA_W-1:0] mem [2**ADDR_W];

    // Write port.
    always_ff @(posedge clk) begin
        if (w_en) mem[w_addr] <= w_data;
    end

    // Registered read port.
    always_ff @(posedge clk) begin
        if (r_en) r_data <= mem[r_addr];
    end
endmodule

// File: rtl/vread_dma.sv
// Fetch engine: reads `size` words over the databus into the local RAM.
module vread_dma import versat_io_pkg::*; #(
    parameter int unsigned DATA_W     = DATA_W_DEF,
    parameter int unsigned MEM_ADDR_W = MEM_ADDR_W_DEF,
    parameter int unsigned IO_ADDR_W  = IO_ADDR_W_DEF,
    parameter int unsigned IO_SIZE_W  = IO_SIZE_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  run,
    input  logic [IO_ADDR_W-1:0]  ext_addr,
    input  logic [MEM_ADDR_W-1:0] int_addr,
    input  logic [IO_SIZE_W-1:0]  size,
    vread_if.master               databus,
    output logic                  mem_we,
    output logic [MEM_ADDR_W-1:0] mem_waddr,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic                  done
);
    localparam int unsigned BPW = bytes_per_word(DATA_W);

    fetch_state_t          state, state_nxt;
    logic [IO_ADDR_W-1:0]  ext_q;
    logic [MEM_ADDR_W-1:0] int_q;
    logic [IO_SIZE_W-1:0]  size_q, cnt;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Latch the transfer on run from IDLE; advance the word count on each accepted beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            ext_q  <= '0;
            int_q  <= '0;
            size_q <= '0;
            cnt    <= '0;
        end else if (state == IDLE && run) begin
            ext_q  <= ext_addr;
            int_q  <= int_addr;
            size_q <= size;
            cnt    <= '0;
        end else if (state == FETCH && databus.ready) begin
            cnt <= cnt + IO_SIZE_W'(1);
        end
    end

    // Next state, bus request and RAM write port.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (run && size != '0) state_nxt = FETCH;
            FETCH: if (databus.ready && cnt == size_q - IO_SIZE_W'(1)) state_nxt = IDLE;
        endcase
        databus.valid = state == FETCH;
        databus.addr  = '0;
        if (state == FETCH) databus.addr = ext_q + IO_ADDR_W'(cnt) * IO_ADDR_W'(BPW);
        databus.wdata = '0;
        databus.wstrb = '0;
        mem_we        = (state == FETCH) && databus.ready;
        mem_waddr     = int_q + MEM_ADDR_W'(cnt);
        mem_wdata     = databus.rdata;
        done          = state == IDLE;
    end
endmodule

// File: rtl/xaddrgen2.sv
// Two-level address generator: an inner period/duty loop nested in an outer loop.
module xaddrgen2 import versat_io_pkg::*; #(
    parameter int unsigned MEM_ADDR_W = MEM_ADDR_W_DEF,
    parameter int unsigned PERIOD_W   = PERIOD_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  run,
    input  logic [MEM_ADDR_W-1:0] iterations,
    input  logic [PERIOD_W-1:0]   period,
    input  logic [PERIOD_W-1:0]   duty,
    input  logic [9:0]            delay,
    input  logic [MEM_ADDR_W-1:0] start,
    input  logic [MEM_ADDR_W-1:0] shift,
    input  logic [MEM_ADDR_W-1:0] incr,
    input  logic [MEM_ADDR_W-1:0] iterations2,
    input  logic [PERIOD_W-1:0]   period2,
    input  logic [MEM_ADDR_W-1:0] shift2,
    input  logic [MEM_ADDR_W-1:0] incr2,
    output logic [MEM_ADDR_W-1:0] addr,
    output logic                  mem_en,
    output logic                  done
);
    agen_state_t           state, state_nxt;
    logic [9:0]            dly_cnt;
    logic [PERIOD_W-1:0]   per_cnt, per2_cnt, per_last, per2_last;
    logic [MEM_ADDR_W-1:0] iter_cnt, iter2_cnt, iter_last, iter2_last;
    logic [MEM_ADDR_W-1:0] base, addr_step, base_step;
    logic                  end_per, end_iter, end_per2, end_all;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= AG_IDLE;
        else     state <= state_nxt;
    end

    // Loop bounds (a zero count still runs one pass), next state and enables.
    always_comb begin
        per_last   = (period == '0)      ? '0 : period - PERIOD_W'(1);
        per2_last  = (period2 == '0)     ? '0 : period2 - PERIOD_W'(1);
        iter_last  = (iterations == '0)  ? '0 : iterations - MEM_ADDR_W'(1);
        iter2_last = (iterations2 == '0) ? '0 : iterations2 - MEM_ADDR_W'(1);
        end_per    = per_cnt == per_last;
        end_iter   = end_per && (iter_cnt == iter_last);
        end_per2   = end_iter && (per2_cnt == per2_last);
        end_all    = end_per2 && (iter2_cnt == iter2_last);
        mem_en     = (state == AG_RUN) && (per_cnt < duty);
        addr_step  = addr + (mem_en ? incr : '0) + (end_per ? shift : '0);
        base_step  = base + incr2 + (end_per2 ? shift2 : '0);
        done       = state == AG_IDLE;
        state_nxt  = state;
        if (run) begin
            state_nxt = (delay == '0) ? AG_RUN : AG_DELAY;
        end else begin
            case (state)
                AG_DELAY: if (dly_cnt == delay - 10'd1) state_nxt = AG_RUN;
                AG_RUN:   if (end_all) state_nxt = AG_IDLE;
                default:  state_nxt = state;
            endcase
        end
    end

    // Loop counters and address; run restarts from start at any time.
    always_ff @(posedge clk) begin
        if (rst) begin
            dly_cnt   <= '0;
            per_cnt   <= '0;
            iter_cnt  <= '0;
            per2_cnt  <= '0;
            iter2_cnt <= '0;
            base      <= '0;
            addr      <= '0;
        end else if (run) begin
            dly_cnt   <= '0;
            per_cnt   <= '0;
            iter_cnt  <= '0;
            per2_cnt  <= '0;
            iter2_cnt <= '0;
            base      <= start;
            addr      <= start;
        end else if (state == AG_DELAY) begin
            dly_cnt <= dly_cnt + 10'd1;
        end else if (state == AG_RUN) begin
            per_cnt <= end_per ? '0 : per_cnt + PERIOD_W'(1);
            if (end_iter) begin
                iter_cnt <= '0;
                base     <= base_step;
                addr     <= base_step;
                if (end_per2) begin
                    per2_cnt  <= '0;
                    iter2_cnt <= iter2_cnt + MEM_ADDR_W'(1);
                end else begin
                    per2_cnt <= per2_cnt + PERIOD_W'(1);
                end
            end else begin
                addr <= addr_step;
                if (end_per) iter_cnt <= iter_cnt + MEM_ADDR_W'(1);
            end
        end
    end
endmodule

// File: rtl/vread.sv
// Versat read unit: DMA fetch into local RAM, address-generated stream out on out0.
module vread import versat_io_pkg::*; #(
    parameter int unsigned DATA_W     = DATA_W_DEF,
    parameter int unsigned MEM_ADDR_W = MEM_ADDR_W_DEF,
    parameter int unsigned IO_ADDR_W  = IO_ADDR_W_DEF,
    parameter int unsigned IO_SIZE_W  = IO_SIZE_W_DEF,
    parameter int unsigned PERIOD_W   = PERIOD_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  run,
    output logic                  done,
    vread_if.master               databus,
    output logic [DATA_W-1:0]     out0,
    input  logic [IO_ADDR_W-1:0]  ext_addr,
    input  logic [MEM_ADDR_W-1:0] int_addr,
    input  logic [IO_SIZE_W-1:0]  size,
    input  logic [MEM_ADDR_W-1:0] iterB,
    input  logic [PERIOD_W-1:0]   perB,
    input  logic [PERIOD_W-1:0]   dutyB,
    input  logic [MEM_ADDR_W-1:0] startB,
    input  logic [MEM_ADDR_W-1:0] shiftB,
    input  logic [MEM_ADDR_W-1:0] incrB,
    input  logic [MEM_ADDR_W-1:0] iter2B,
    input  logic [PERIOD_W-1:0]   per2B,
    input  logic [MEM_ADDR_W-1:0] shift2B,
    input  logic [MEM_ADDR_W-1:0] incr2B,
    input  logic [31:0]           delay0,
    input  logic                  reverseB
);
    logic                  doneA, doneB, mem_we, mem_en, rd_vld;
    logic [MEM_ADDR_W-1:0] mem_waddr, addrB, raddr;
    logic [DATA_W-1:0]     mem_wdata, mem_rdata;
    logic [21:0]           unused_delay;

    assign unused_delay = delay0[31:10];

    function automatic logic [MEM_ADDR_W-1:0] bit_rev(input logic [MEM_ADDR_W-1:0] a);
        logic [MEM_ADDR_W-1:0] r;
        r = '0;
        for (int unsigned i = 0; i < MEM_ADDR_W; i++) r[i] = a[MEM_ADDR_W-1-i];
        return r;
    endfunction

    vread_dma #(
        .DATA_W(DATA_W), .MEM_ADDR_W(MEM_ADDR_W), .IO_ADDR_W(IO_ADDR_W), .IO_SIZE_W(IO_SIZE_W)
    ) u_dma (
        .clk(clk), .rst(rst), .run(run),
        .ext_addr(ext_addr), .int_addr(int_addr), .size(size),
        .databus(databus),
        .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
        .done(doneA)
    );

    xaddrgen2 #(.MEM_ADDR_W(MEM_ADDR_W), .PERIOD_W(PERIOD_W)) u_agen (
        .clk(clk), .rst(rst), .run(run),
        .iterations(iterB), .period(perB), .duty(dutyB), .delay(delay0[9:0]),
        .start(startB), .shift(shiftB), .incr(incrB),
        .iterations2(iter2B), .period2(per2B), .shift2(shift2B), .incr2(incr2B),
        .addr(addrB), .mem_en(mem_en), .done(doneB)
    );

    iob_2p_ram #(.DATA_W(DATA_W), .ADDR_W(MEM_ADDR_W)) u_ram (
        .clk(clk),
        .w_en(mem_we), .w_addr(mem_waddr), .w_data(mem_wdata),
        .r_en(mem_en), .r_addr(raddr), .r_data(mem_rdata)
    );

    // Optional bit-reversed read addressing for FFT ordering.
    always_comb begin
        raddr = reverseB ? bit_rev(addrB) : addrB;
    end

    // out0 captures RAM data one cycle after the read; holds otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_vld <= 1'b0;
            out0   <= '0;
        end else begin
            rd_vld <= mem_en;
            if (rd_vld) out0 <= mem_rdata;
        end
    end

    assign done = doneA & doneB;
endmodule

// File: tb/tb_vread.sv
// Self-checking bench for vread with a 3-bit local RAM.
module tb_vread;
    localparam int unsigned DW = 32, MAW = 3, IAW = 32, ISW = 11, PW = 10;
    localparam int unsigned DEPTH = 1 << MAW;

    logic           clk = 1'b0;
    logic           rst, run, done, reverseB;
    logic [DW-1:0]  out0;
    logic [IAW-1:0] ext_addr;
    logic [MAW-1:0] int_addr, iterB, startB, shiftB, incrB, iter2B, shift2B, incr2B;
    logic [ISW-1:0] size;
    logic [PW-1:0]  perB, dutyB, per2B;
    logic [31:0]    delay0;

    vread_if #(.DATA_W(DW), .IO_ADDR_W(IAW)) bus ();

    vread #(.DATA_W(DW), .MEM_ADDR_W(MAW), .IO_ADDR_W(IAW), .IO_SIZE_W(ISW), .PERIOD_W(PW)) dut (
        .clk(clk), .rst(rst), .run(run), .done(done), .databus(bus), .out0(out0),
        .ext_addr(ext_addr), .int_addr(int_addr), .size(size),
        .iterB(iterB), .perB(perB), .dutyB(dutyB), .startB(startB), .shiftB(shiftB), .incrB(incrB),
        .iter2B(iter2B), .per2B(per2B), .shift2B(shift2B), .incr2B(incr2B),
        .delay0(delay0), .reverseB(reverseB)
    );

    always #5 clk = ~clk;

    int          tests = 0;
    int          fails = 0;
    logic [31:0] ref_ram [DEPTH];
    logic [31:0] exp_out0;
    logic [31:0] key;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [31:0] ext_word(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ key;
    endfunction

    function automatic int unsigned rev3(input int unsigned j);
        return ((j & 1) << 2) | (j & 2) | ((j >> 2) & 1);
    endfunction

    task automatic quiet_b();
        iterB = '0; perB = '0; dutyB = '0; startB = '0; shiftB = '0; incrB = '0;
        iter2B = '0; per2B = '0; shift2B = '0; incr2B = '0; delay0 = '0; reverseB = 1'b0;
    endtask

    // mode: 0 ready always, 1 ready on every third cycle, 2 random ready
    task automatic fetch(input logic [31:0] ext, input int unsigned ia, input int unsigned sz,
                         input int unsigned mode, input int abort_at);
        int unsigned k, cyc;
        logic rdy;
        quiet_b();
        ext_addr = ext; int_addr = MAW'(ia); size = ISW'(sz); run = 1'b1;
        step();
        run = 1'b0;
        k = 0; cyc = 0;
        while (k < sz && cyc < 200) begin
            chk("fetch_valid", bus.valid, 1);
            chk("fetch_addr", bus.addr, ext + 4 * k);
            chk("fetch_done", done, 0);
            if (abort_at >= 0 && cyc == abort_at) begin
                bus.ready = 1'b0; rst = 1'b1;
                step();
                rst = 1'b0;
                chk("abort_valid", bus.valid, 0);
                chk("abort_done", done, 1);
                chk("abort_out0", out0, 0);
                exp_out0 = '0;
                return;
            end
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = (cyc % 3 == 0);
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            bus.ready = rdy;
            bus.rdata = ext_word(bus.addr);
            if (rdy) begin
                ref_ram[(ia + k) % DEPTH] = ext_word(ext + 4 * k);
                k++;
            end
            step();
            cyc++;
        end
        bus.ready = 1'b0;
        chk("fetch_count", k, sz);
        chk("fetch_end_valid", bus.valid, 0);
        chk("fetch_end_done", done, 1);
    endtask

    // Stream 8 consecutive RAM words (from st, optionally bit-reversed) after d delay cycles.
    task automatic bread(input int unsigned st, input logic rev, input int unsigned d);
        int unsigned a;
        ext_addr = '0; int_addr = '0; size = '0;
        iterB = 1; perB = 8; dutyB = 8; startB = MAW'(st); shiftB = 0; incrB = 1;
        iter2B = 0; per2B = 0; shift2B = 0; incr2B = 0;
        delay0 = ($urandom & 32'hFFFF_FC00) | 32'(d);
        reverseB = rev; run = 1'b1;
        step();
        run = 1'b0;
        chk("b_done_start", done, 0);
        for (int unsigned m = 1; m <= d + 10; m++) begin
            step();
            if (m >= d + 2 && m - d - 2 < 8) begin
                a = (st + m - d - 2) % DEPTH;
                if (rev) a = rev3(a);
                exp_out0 = ref_ram[a];
            end
            chk("b_out0", out0, exp_out0);
            chk("b_valid", bus.valid, 0);
            chk("b_done", done, 32'(m >= d + 8));
        end
    endtask

    initial begin
        key = $urandom;
        rst = 1'b1; run = 1'b1;
        bus.ready = 1'b0; bus.rdata = '0;
        quiet_b();
        ext_addr = 32'h100; int_addr = '0; size = 4;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("reset_done", done, 1);
            chk("reset_valid", bus.valid, 0);
            chk("reset_out0", out0, 0);
            chk("reset_addr", bus.addr, 0);
        end
        chk("tied_wdata", bus.wdata, 0);
        chk("tied_wstrb", 32'(bus.wstrb), 0);
        rst = 1'b0; run = 1'b0;
        exp_out0 = '0;
        step();

        fetch(32'h100, 0, 4, 0, -1);
        fetch(32'h200, 4, 4, 1, -1);
        bread(0, 1'b1, 0);
        bread($urandom_range(0, DEPTH - 1), 1'b0, $urandom_range(0, 3));

        fetch(32'($urandom_range(0, 16383)) << 2, $urandom_range(0, DEPTH - 1),
              $urandom_range(1, 8), 2, -1);
        bread($urandom_range(0, DEPTH - 1), 1'($urandom_range(0, 1)), $urandom_range(0, 3));

        fetch(32'h4000, DEPTH - 2, 4, 0, -1);
        bread(0, 1'b0, 1);

        fetch(32'h800, 3, 8, 0, 3);
        bread(0, 1'b0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
